// File: rtl/pattern_pkg.sv
// Shared constants for the serial 3-bit pattern detector and its scan controller.
package pattern_pkg;

  // Default match patterns; window[2] holds the oldest bit.
  localparam logic [2:0] PAT_A_DEF = 3'b111;
  localparam logic [2:0] PAT_B_DEF = 3'b001;

  // Controller states, kept as plain 2-bit constants for legacy tools.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // True when a 3-bit window equals either pattern.
  function automatic logic win_hit(input logic [2:0] win,
                                   input logic [2:0] pat_a,
                                   input logic [2:0] pat_b);
    return (win == pat_a) || (win == pat_b);
  endfunction

endpackage

// File: rtl/pattern_window.sv
// 3-bit detector window: clears on word load, shifts one bit per enable and
// flags a match on the window value that the current bit is about to form.
module pattern_window
  import pattern_pkg::*;
#(
  parameter logic [2:0] PAT_A = PAT_A_DEF,
  parameter logic [2:0] PAT_B = PAT_B_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic shift_en_i,
  input  logic bit_i,
  input  logic qualify_i,
  output logic match_o
);

  logic [2:0] window_q;
  logic [2:0] window_d;
  logic [2:0] win_next_s;

  assign win_next_s = {window_q[1:0], bit_i};

  // Next window value and Mealy match on it; unqualified windows never match.
  always_comb begin
    window_d = window_q;
    match_o  = 1'b0;
    if (clr_i) begin
      window_d = 3'b000;
    end else if (shift_en_i) begin
      window_d = win_next_s;
      match_o  = qualify_i && win_hit(win_next_s, PAT_A, PAT_B);
    end else begin
      window_d = window_q;
    end
  end

  // Window register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      window_q <= 3'b000;
    end else begin
      window_q <= window_d;
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Scan controller: takes a word over a valid/ready handshake, shifts it MSB-first
// through the detector window, counts matches, records the first match position
// and offers the result over a second valid/ready handshake.
module pattern_scan_ctrl
  import pattern_pkg::*;
#(
  parameter int          WORD_W = 10,
  parameter logic [2:0]  PAT_A  = PAT_A_DEF,
  parameter logic [2:0]  PAT_B  = PAT_B_DEF,
  localparam int         CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic [CNT_W-1:0]  res_first,
  output logic              match,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  first_q, first_d;

  logic [CNT_W-1:0]  k_plus1_s;
  logic              qualify_s;
  logic              last_bit_s;
  logic              win_clr_s;
  logic              shift_en_s;
  logic              match_s;

  assign k_plus1_s  = k_q + CNT_W'(1);
  assign qualify_s  = (k_plus1_s >= CNT_W'(3));
  assign last_bit_s = (k_plus1_s == CNT_W'(WORD_W));

  pattern_window #(
    .PAT_A (PAT_A),
    .PAT_B (PAT_B)
  ) u_window (
    .clock      (clock),
    .reset      (reset),
    .clr_i      (win_clr_s),
    .shift_en_i (shift_en_s),
    .bit_i      (sreg_q[WORD_W-1]),
    .qualify_i  (qualify_s),
    .match_o    (match_s)
  );

  // FSM next state plus shift register, bit counter and result updates.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    k_d        = k_q;
    count_d    = count_q;
    first_d    = first_q;
    win_clr_s  = 1'b0;
    shift_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_SHIFT;
          sreg_d    = in_word;
          k_d       = '0;
          count_d   = '0;
          first_d   = '0;
          win_clr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_en_s = 1'b1;
        sreg_d     = {sreg_q[WORD_W-2:0], 1'b0};
        k_d        = k_plus1_s;
        if (match_s) begin
          count_d = count_q + CNT_W'(1);
          if (first_q == '0) begin
            first_d = k_plus1_s;
          end else begin
            first_d = first_q;
          end
        end else begin
          count_d = count_q;
        end
        if (last_bit_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight word or result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      k_q     <= '0;
      count_q <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      k_q     <= k_d;
      count_q <= count_d;
      first_q <= first_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign res_count = count_q;
  assign res_first = first_q;
  assign match     = match_s;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: expected results are queued when a
// word is accepted and compared when the result handshake completes.
module tb_pattern_scan_ctrl;

  localparam int W  = 10;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_word;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_count;
  logic [CW-1:0] res_first;
  logic          match;
  logic          busy;

  pattern_scan_ctrl #(.WORD_W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
    .res_first (res_first),
    .match     (match),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int cnt;
    int first;
  } exp_t;

  exp_t sb_q[$];

  int mon_k, mon_cnt, mon_first, acc_cyc, hs_cyc;
  bit done_seen;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the word MSB-first through a 3-bit history.
  function automatic exp_t model(input logic [W-1:0] w);
    logic [2:0] h;
    exp_t e;
    h = 3'b000;
    e.cnt = 0;
    e.first = 0;
    for (int i = 1; i <= W; i++) begin
      h = {h[1:0], w[W-i]};
      if (i >= 3 && (h == 3'b111 || h == 3'b001)) begin
        e.cnt++;
        if (e.first == 0) e.first = i;
      end
    end
    return e;
  endfunction

  // Monitor: pushes on acceptance, traces match pulses, pops on result handshake.
  always @(negedge clock) begin
    if (!reset) begin
      if (in_valid && in_ready) begin
        sb_q.push_back(model(in_word));
        acc_cyc   = cyc + 1;
        mon_k     = 0;
        mon_cnt   = 0;
        mon_first = 0;
        done_seen = 1'b0;
      end
      if (busy && !res_valid) begin
        mon_k++;
        if (match) begin
          mon_cnt++;
          if (mon_first == 0) mon_first = mon_k;
        end
      end else begin
        chk("match_outside_shift", int'(match), 0);
      end
      if (res_valid) begin
        chk("in_ready_in_done", int'(in_ready), 0);
        chk("sb_nonempty", (sb_q.size() > 0) ? 1 : 0, 1);
        if (sb_q.size() > 0) begin
          if (!done_seen) begin
            chk("latency", cyc - acc_cyc, W);
            done_seen = 1'b1;
          end
          chk("res_count", int'(res_count), sb_q[0].cnt);
          chk("res_first", int'(res_first), sb_q[0].first);
          if (res_ready) begin
            chk("match_pulses", mon_cnt, sb_q[0].cnt);
            chk("match_first_k", mon_first, sb_q[0].first);
            chk("shift_cycles", mon_k, W);
            void'(sb_q.pop_front());
            hs_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready && n < 100);
    chk("wait_in_ready", int'(in_ready), 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!res_valid && n < 100);
    chk("wait_res_valid", int'(res_valid), 1);
  endtask

  // One word, optional DONE stall of 'stall' cycles with res_ready low.
  task automatic run_word(input logic [W-1:0] w, input int stall);
    @(posedge clock);
    #1;
    res_ready = (stall == 0);
    in_word   = w;
    in_valid  = 1'b1;
    wait_ready();
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_word  = W'($urandom);
    wait_valid();
    if (stall > 0) begin
      repeat (stall - 1) @(negedge clock);
      @(posedge clock);
      #1;
      res_ready = 1'b1;
      @(negedge clock);
    end
    @(negedge clock);
    chk("idle_after_handshake", int'(in_ready), 1);
    chk("idle_gap", cyc - hs_cyc, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    in_word   = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_match", int'(match), 0);
    chk("rst_count", int'(res_count), 0);
    chk("rst_first", int'(res_first), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Tests 1-3: mixed, all zero, all one.
    run_word(10'b1110011001, 0);
    run_word(10'b0000000000, 0);
    run_word(10'b1111111111, 0);

    // Test 4: result held five cycles with res_ready low.
    run_word(10'b1110011001, 5);

    // Test 5: reset after five bits of a scan.
    @(posedge clock);
    #1;
    res_ready = 1'b1;
    in_word   = 10'b1110011001;
    in_valid  = 1'b1;
    wait_ready();
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    sb_q.delete();
    done_seen = 1'b0;
    @(negedge clock);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_res_valid", int'(res_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_count", int'(res_count), 0);
    run_word(10'b0100100111, 0);

    // Test 6: in_valid held high across two back-to-back words.
    @(posedge clock);
    #1;
    res_ready = 1'b1;
    in_word   = 10'b1011100101;
    in_valid  = 1'b1;
    wait_ready();
    @(posedge clock);
    #1;
    in_word = 10'b0011111001;
    wait_valid();
    wait_ready();
    chk("b2b_accept_gap", cyc - hs_cyc, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    wait_valid();
    @(negedge clock);
    chk("b2b_idle", int'(in_ready), 1);

    // A few random words.
    for (int i = 0; i < 6; i++) begin
      run_word(W'($urandom), (i % 3));
    end

    repeat (2) @(negedge clock);
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
